sc_level_timer: RTL

- Timing responder for the game-speed controller.
- Takes the reload period and load strobe from the controller and counts down at 50 MHz.
- Returns a one-cycle timer tick and a level count to the controller.
- The controller uses the level count to pick the next period and the mux selects, which closes the pacing loop for the road/obstacle shift logic.

---
 rtl/sc_game_pkg.sv | 34 +++
 rtl/sc_downcounter.sv | 45 ++++
 rtl/sc_level_timer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sc_game_pkg.sv
// ----------------------------------------------------------------------------
// sc_game_pkg
// Shared definitions for the game-speed controller and its level timer.
// Holds the timer FSM state encoding, default datapath widths, the
// controller's tick periods (in 50 MHz clock cycles) and the level band
// boundaries used by the controller to pick those periods.
// ----------------------------------------------------------------------------
package sc_game_pkg;

  // Level timer operating states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sc_timer_state_e;

  // Default datapath widths.
  localparam int TIMER_WIDTH_DEF = 32;
  localparam int LEVEL_WIDTH_DEF = 8;

  // Controller tick periods in clock cycles at 50 MHz.
  localparam logic [31:0] PERIOD_SLOW = 32'd17500000;  // 0.35 s
  localparam logic [31:0] PERIOD_MID  = 32'd15000000;  // 0.30 s
  localparam logic [31:0] PERIOD_FAST = 32'd12500000;  // 0.25 s

  // Level band boundaries shared with the controller.
  localparam int LEVEL_BAND_0 = 10;
  localparam int LEVEL_BAND_1 = 17;
  localparam int LEVEL_BAND_2 = 32;
  localparam int LEVEL_BAND_3 = 39;
  localparam int LEVEL_BAND_4 = 59;

endpackage

// File: rtl/sc_downcounter.sv
// ----------------------------------------------------------------------------
// sc_downcounter
// Loadable down-counter that stops at zero.
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset, clears the value
//   en          in   decrement enable (ignored once the value is zero)
//   load        in   load strobe, has priority over en
//   load_value  in   value captured on load
//   value       out  registered counter value
//   zero        out  high while the registered value is zero
// ----------------------------------------------------------------------------
module sc_downcounter
  import sc_game_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] value_r;

  // Counter register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_r <= '0;
    end else if (load) begin
      value_r <= load_value;
    end else if (en && (value_r != '0)) begin
      value_r <= value_r - WIDTH'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign zero  = (value_r == '0);

endmodule

// File: rtl/sc_level_timer.sv
// ----------------------------------------------------------------------------
// sc_level_timer
// Timing responder for the game-speed controller. Counts down a reload
// period at 50 MHz, emits a one-cycle tick on every expiry and advances a
// level count every TICKS_PER_LEVEL ticks until LEVEL_MAX ends the run.
// Ports:
//   SC_LEVELTIMER_CLOCK_50      in   system clock, 50 MHz
//   SC_LEVELTIMER_RESET_InLow   in   synchronous active-low reset
//   SC_LEVELTIMER_START_InLow   in   start request (active-low, level)
//   SC_LEVELTIMER_PAUSE_InHigh  in   freeze counting while high
//   SC_LEVELTIMER_PERIOD_IN     in   reload period in clock cycles
//   SC_LEVELTIMER_LOAD_InHigh   in   reload strobe
//   SC_LEVELTIMER_TICK_OUT      out  one-cycle pulse per period expiry
//   SC_LEVELTIMER_LEVEL_OUT     out  current level
//   SC_LEVELTIMER_COUNT_OUT     out  current down-counter value
//   SC_LEVELTIMER_DONE_OUT      out  high once LEVEL_MAX is reached
//   SC_LEVELTIMER_BUSY_OUT      out  high in RUN or PAUSE
// All outputs are registered.
// ----------------------------------------------------------------------------
module sc_level_timer
  import sc_game_pkg::*;
#(
  parameter int TIMER_WIDTH     = TIMER_WIDTH_DEF,
  parameter int LEVEL_WIDTH     = LEVEL_WIDTH_DEF,
  parameter int TICKS_PER_LEVEL = 16,
  parameter int LEVEL_MAX       = 59
) (
  input  logic                   SC_LEVELTIMER_CLOCK_50,
  input  logic                   SC_LEVELTIMER_RESET_InLow,
  input  logic                   SC_LEVELTIMER_START_InLow,
  input  logic                   SC_LEVELTIMER_PAUSE_InHigh,
  input  logic [TIMER_WIDTH-1:0] SC_LEVELTIMER_PERIOD_IN,
  input  logic                   SC_LEVELTIMER_LOAD_InHigh,
  output logic                   SC_LEVELTIMER_TICK_OUT,
  output logic [LEVEL_WIDTH-1:0] SC_LEVELTIMER_LEVEL_OUT,
  output logic [TIMER_WIDTH-1:0] SC_LEVELTIMER_COUNT_OUT,
  output logic                   SC_LEVELTIMER_DONE_OUT,
  output logic                   SC_LEVELTIMER_BUSY_OUT
);

  // Tick-in-level counter needs at least one bit even for TICKS_PER_LEVEL=1.
  localparam int TCW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [TCW-1:0]         TPL_LAST  = TCW'(TICKS_PER_LEVEL - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_MAX_C = LEVEL_WIDTH'(LEVEL_MAX);

  // Elaboration-time parameter sanity.
  if ((LEVEL_MAX >> LEVEL_WIDTH) != 0) begin : g_level_max_chk
    $error("sc_level_timer: LEVEL_MAX does not fit in LEVEL_WIDTH bits");
  end
  if (TICKS_PER_LEVEL < 1) begin : g_tpl_chk
    $error("sc_level_timer: TICKS_PER_LEVEL must be 1 or more");
  end

  // A zero period would never expire; treat it as one cycle.
  function automatic logic [TIMER_WIDTH-1:0] clamp_period(
    input logic [TIMER_WIDTH-1:0] p
  );
    if (p == '0) begin
      return TIMER_WIDTH'(1);
    end else begin
      return p;
    end
  endfunction

  sc_timer_state_e        state_r, state_nxt_s;
  logic [TIMER_WIDTH-1:0] period_r, period_nxt_s;
  logic [LEVEL_WIDTH-1:0] level_r, level_nxt_s;
  logic [TCW-1:0]         tcnt_r, tcnt_nxt_s;
  logic                   tick_r, tick_nxt_s;
  logic                   done_r, busy_r;
  logic [TIMER_WIDTH-1:0] new_period_s;
  logic                   cnt_load_s, cnt_en_s, cnt_zero_s;
  logic [TIMER_WIDTH-1:0] cnt_val_s, cnt_value_s;

  assign new_period_s = clamp_period(SC_LEVELTIMER_PERIOD_IN);

  sc_downcounter #(
    .WIDTH (TIMER_WIDTH)
  ) u_downcounter (
    .clk        (SC_LEVELTIMER_CLOCK_50),
    .rst_n      (SC_LEVELTIMER_RESET_InLow),
    .en         (cnt_en_s),
    .load       (cnt_load_s),
    .load_value (cnt_val_s),
    .value      (cnt_value_s),
    .zero       (cnt_zero_s)
  );

  // Next-state, counter control, tick and level decisions.
  always_comb begin
    state_nxt_s  = state_r;
    period_nxt_s = period_r;
    level_nxt_s  = level_r;
    tcnt_nxt_s   = tcnt_r;
    tick_nxt_s   = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_en_s     = 1'b0;
    cnt_val_s    = period_r - TIMER_WIDTH'(1);

    case (state_r)
      IDLE: begin
        if (!SC_LEVELTIMER_START_InLow) begin
          state_nxt_s  = RUN;
          period_nxt_s = new_period_s;
          cnt_load_s   = 1'b1;
          cnt_val_s    = new_period_s - TIMER_WIDTH'(1);
          level_nxt_s  = '0;
          tcnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      RUN: begin
        // A reload overrides the expiry reload value but not the tick.
        if (SC_LEVELTIMER_LOAD_InHigh) begin
          period_nxt_s = new_period_s;
          cnt_load_s   = 1'b1;
          cnt_val_s    = new_period_s - TIMER_WIDTH'(1);
        end else begin
          cnt_val_s = period_r - TIMER_WIDTH'(1);
        end

        // Pause outranks expiry on the cycle it is sampled.
        if (SC_LEVELTIMER_PAUSE_InHigh) begin
          state_nxt_s = PAUSE;
        end else if (cnt_zero_s) begin
          tick_nxt_s = 1'b1;
          cnt_load_s = 1'b1;
          if (tcnt_r == TPL_LAST) begin
            tcnt_nxt_s = '0;
            if (level_r != LVL_MAX_C) begin
              level_nxt_s = level_r + LEVEL_WIDTH'(1);
            end else begin
              level_nxt_s = level_r;
            end
            if ((level_r + LEVEL_WIDTH'(1)) == LVL_MAX_C) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            tcnt_nxt_s = tcnt_r + TCW'(1);
          end
        end else begin
          cnt_en_s = 1'b1;
        end
      end

      PAUSE: begin
        if (SC_LEVELTIMER_LOAD_InHigh) begin
          period_nxt_s = new_period_s;
          cnt_load_s   = 1'b1;
          cnt_val_s    = new_period_s - TIMER_WIDTH'(1);
        end else begin
          cnt_load_s = 1'b0;
        end
        if (!SC_LEVELTIMER_PAUSE_InHigh) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PAUSE;
        end
      end

      DONE: begin
        state_nxt_s = DONE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, period, level and registered status outputs.
  always_ff @(posedge SC_LEVELTIMER_CLOCK_50) begin
    if (!SC_LEVELTIMER_RESET_InLow) begin
      state_r  <= IDLE;
      period_r <= '0;
      level_r  <= '0;
      tcnt_r   <= '0;
      tick_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      period_r <= period_nxt_s;
      level_r  <= level_nxt_s;
      tcnt_r   <= tcnt_nxt_s;
      tick_r   <= tick_nxt_s;
      done_r   <= (state_nxt_s == DONE);
      busy_r   <= (state_nxt_s == RUN) || (state_nxt_s == PAUSE);
    end
  end

  assign SC_LEVELTIMER_TICK_OUT  = tick_r;
  assign SC_LEVELTIMER_LEVEL_OUT = level_r;
  assign SC_LEVELTIMER_COUNT_OUT = cnt_value_s;
  assign SC_LEVELTIMER_DONE_OUT  = done_r;
  assign SC_LEVELTIMER_BUSY_OUT  = busy_r;

endmodule
